// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline sequencer: controller states and PC source selects.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DWAIT  = 2'b01,
    HALTED = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_BR  = 2'b01,
    PC_J   = 2'b10,
    PC_JR  = 2'b11
  } pc_sel_e;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use comparator: the instruction in ID needs a value that a load in EX
// has not produced yet. Register 0 never carries a dependency.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic       ex_load,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  output logic       load_use
);

  assign load_use = ex_load && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: turns cache handshakes, hazards, MEM-stage redirects and
// halt into per-latch enable/flush strobes, PC steering and status counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 64,
  parameter int CNTW       = 16
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            ihit,
  input  logic            dhit,
  input  logic            mem_dREN,
  input  logic            mem_dWEN,
  input  logic            mem_branch_taken,
  input  logic            mem_jump,
  input  logic            mem_jreg,
  input  logic            mem_halt,
  input  logic            ex_load,
  input  logic [4:0]      ex_rt,
  input  logic [4:0]      id_rs,
  input  logic [4:0]      id_rt,
  input  logic            id_uses_rt,
  output logic            pc_en,
  output logic [1:0]      pc_sel,
  output logic            ifid_en,
  output logic            idex_en,
  output logic            exmem_en,
  output logic            memwb_en,
  output logic            ifid_flush,
  output logic            idex_flush,
  output logic            exmem_flush,
  output logic            memwb_flush,
  output logic            halt_out,
  output logic            mem_timeout,
  output logic [CNTW-1:0] stall_count
);

  localparam int WCW = $clog2(WAIT_LIMIT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_LIMIT - 1);

  state_e         state, state_next;
  pc_sel_e        sel;
  logic [WCW-1:0] wait_cnt;
  logic           dpend;
  logic           redirect;
  logic           load_use;

  hazard_detect u_hazard (
    .ex_load    (ex_load),
    .ex_rt      (ex_rt),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .load_use   (load_use)
  );

  assign dpend    = (mem_dREN || mem_dWEN) && !dhit;
  assign redirect = mem_branch_taken || mem_jump || mem_jreg;
  assign pc_sel   = sel;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case can infer a latch.
    state_next  = state;
    sel         = PC_SEQ;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;

    case (state)
      RUN, DWAIT: begin
        // A DWAIT cycle whose access completes advances exactly like RUN.
        if (dpend) begin
          state_next = DWAIT;
        end else begin
          state_next = RUN;
          if (mem_halt) begin
            memwb_en    = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            state_next  = HALTED;
          end else if (redirect) begin
            memwb_en    = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            pc_en       = 1'b1;
            sel         = mem_jreg ? PC_JR : (mem_jump ? PC_J : PC_BR);
          end else if (load_use) begin
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
          end else if (!ihit) begin
            ifid_flush = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
          end else begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
          end
        end
      end
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase

    // Latches must not move while the datapath is being reset.
    if (!nRST) begin
      sel         = PC_SEQ;
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      memwb_flush = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= RUN;
      halt_out    <= 1'b0;
      mem_timeout <= 1'b0;
      stall_count <= '0;
      wait_cnt    <= '0;
    end else begin
      state    <= state_next;
      halt_out <= (state_next == HALTED);

      if (state == DWAIT) begin
        if (dpend && (wait_cnt == WAIT_LAST))
          mem_timeout <= 1'b1;
        if (wait_cnt != WAIT_LAST)
          wait_cnt <= wait_cnt + 1'b1;
      end else if (dpend) begin
        wait_cnt <= '0;
      end

      if ((state != HALTED) && !pc_en && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios then randomized
// traffic, every cycle compared against a rule-level model of the sequencer.
module tb_pipeline_ctrl;

  localparam int WL   = 4;
  localparam int CW   = 5;
  localparam int SMAX = (1 << CW) - 1;

  typedef struct packed {
    bit       ihit, dhit, dren, dwen, br, j, jr, halt, ex_load, uses_rt;
    bit [4:0] ex_rt, id_rs, id_rt;
  } stim_t;

  typedef struct packed {
    bit       pc_en;
    bit [1:0] pc_sel;
    bit [3:0] en;   // {ifid, idex, exmem, memwb}
    bit [3:0] fl;
  } ctl_t;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          ihit, dhit, mem_dREN, mem_dWEN;
  logic          mem_branch_taken, mem_jump, mem_jreg, mem_halt;
  logic          ex_load, id_uses_rt;
  logic [4:0]    ex_rt, id_rs, id_rt;
  logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic          ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic [1:0]    pc_sel;
  logic          halt_out, mem_timeout;
  logic [CW-1:0] stall_count;

  pipeline_ctrl #(.WAIT_LIMIT(WL), .CNTW(CW)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
    .mem_branch_taken(mem_branch_taken), .mem_jump(mem_jump),
    .mem_jreg(mem_jreg), .mem_halt(mem_halt),
    .ex_load(ex_load), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt),
    .pc_en(pc_en), .pc_sel(pc_sel),
    .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
    .halt_out(halt_out), .mem_timeout(mem_timeout), .stall_count(stall_count)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  // Model state: what the controller must have remembered so far.
  bit m_halted, m_wait, m_tmo;
  int m_dcnt, m_stall;

  logic       obs_pc_en;
  logic [1:0] obs_pc_sel;
  logic [3:0] obs_en, obs_fl;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ctl_t model_ctl(input stim_t s, input bit rst);
    ctl_t r;
    bit dp, lu;
    r = '0;
    if (rst || m_halted) return r;
    dp = (s.dren || s.dwen) && !s.dhit;
    if (dp) return r;
    lu = s.ex_load && (s.ex_rt != 0) &&
         ((s.ex_rt == s.id_rs) || (s.uses_rt && (s.ex_rt == s.id_rt)));
    if (s.halt) begin
      r.en = 4'b0001; r.fl = 4'b1110;
    end else if (s.br || s.j || s.jr) begin
      r.en = 4'b0001; r.fl = 4'b1110; r.pc_en = 1'b1;
      r.pc_sel = s.jr ? 2'd3 : (s.j ? 2'd2 : 2'd1);
    end else if (lu) begin
      r.en = 4'b0011; r.fl = 4'b0100;
    end else if (!s.ihit) begin
      r.en = 4'b0111; r.fl = 4'b1000;
    end else begin
      r.en = 4'b1111; r.pc_en = 1'b1;
    end
    return r;
  endfunction

  // One clock cycle: drive, compare everything against the model, advance the model.
  task automatic step(input stim_t s, input bit rst);
    ctl_t exp;
    bit dp, nh;
    ihit = s.ihit; dhit = s.dhit; mem_dREN = s.dren; mem_dWEN = s.dwen;
    mem_branch_taken = s.br; mem_jump = s.j; mem_jreg = s.jr; mem_halt = s.halt;
    ex_load = s.ex_load; ex_rt = s.ex_rt; id_rs = s.id_rs; id_rt = s.id_rt;
    id_uses_rt = s.uses_rt;
    nRST = !rst;
    #3;
    if (rst) begin
      m_halted = 0; m_wait = 0; m_tmo = 0; m_dcnt = 0; m_stall = 0;
    end
    exp = model_ctl(s, rst);
    obs_pc_en  = pc_en;
    obs_pc_sel = pc_sel;
    obs_en     = {ifid_en, idex_en, exmem_en, memwb_en};
    obs_fl     = {ifid_flush, idex_flush, exmem_flush, memwb_flush};
    check("pc_en", obs_pc_en, exp.pc_en);
    check("pc_sel", obs_pc_sel, exp.pc_sel);
    check("latch_en", obs_en, exp.en);
    check("latch_flush", obs_fl, exp.fl);
    check("halt_out", halt_out, m_halted);
    check("mem_timeout", mem_timeout, m_tmo);
    check("stall_count", stall_count, m_stall);
    if (!rst) begin
      dp = (s.dren || s.dwen) && !s.dhit;
      if (!m_halted && !exp.pc_en && m_stall < SMAX) m_stall++;
      if (!m_halted && m_wait && dp && m_dcnt == WL - 1) m_tmo = 1;
      if (m_wait) m_dcnt++;
      else m_dcnt = 0;
      nh = m_halted || (!dp && s.halt);
      m_wait = !m_halted && dp;
      m_halted = nh;
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    stim_t s;
    stim_t idle;
    bit rst;
    idle = '0;
    @(posedge CLK);
    #1;

    // Reset state
    step(idle, 1'b1);
    step(idle, 1'b1);
    check("rst_en", obs_en, 4'b0000);
    check("rst_pc_en", obs_pc_en, 1'b0);

    // Clean streaming
    s = idle; s.ihit = 1;
    repeat (5) step(s, 1'b0);
    check("run_en", obs_en, 4'b1111);
    check("run_pc_en", obs_pc_en, 1'b1);
    check("run_pc_sel", obs_pc_sel, 2'b00);
    check("run_stall", stall_count, 0);

    // Data miss for 3 cycles, then hit
    s.dren = 1; s.dhit = 0;
    for (int i = 0; i < 3; i++) begin
      step(s, 1'b0);
      check("dwait_en", obs_en, 4'b0000);
    end
    s.dhit = 1;
    step(s, 1'b0);
    check("dhit_en", obs_en, 4'b1111);
    check("dwait_stall", stall_count, 3);

    // Watchdog: one RUN miss plus WL DWAIT misses
    s.dhit = 0;
    for (int i = 0; i < 5; i++) begin
      step(s, 1'b0);
      if (i == 3) check("timeout_early", mem_timeout, 1'b0);
    end
    check("timeout_set", mem_timeout, 1'b1);
    s.dhit = 1;
    step(s, 1'b0);
    s.dren = 0;
    step(s, 1'b0);
    check("timeout_sticky", mem_timeout, 1'b1);

    // Load-use
    s = idle; s.ihit = 1; s.ex_load = 1; s.ex_rt = 5; s.id_rs = 5;
    step(s, 1'b0);
    check("lu_pc_en", obs_pc_en, 1'b0);
    check("lu_ifid_en", obs_en[3], 1'b0);
    check("lu_idex_flush", obs_fl[2], 1'b1);
    s.ex_rt = 0; s.id_rs = 0;
    step(s, 1'b0);
    check("lu_r0_pc_en", obs_pc_en, 1'b1);

    // Redirect with jreg + branch while fetch misses
    s = idle; s.jr = 1; s.br = 1;
    step(s, 1'b0);
    check("jr_pc_sel", obs_pc_sel, 2'b11);
    check("jr_flush", obs_fl, 4'b1110);
    check("jr_pc_en", obs_pc_en, 1'b1);

    // Halt
    s = idle; s.ihit = 1; s.halt = 1;
    step(s, 1'b0);
    check("halt_memwb_en", obs_en[0], 1'b1);
    check("halt_out_set", halt_out, 1'b1);
    s.halt = 0;
    for (int i = 0; i < 3; i++) begin
      step(s, 1'b0);
      check("halted_en", obs_en, 4'b0000);
    end
    step(idle, 1'b1);
    check("halt_cleared", halt_out, 1'b0);

    // Reset in the middle of a data wait
    s = idle; s.ihit = 1; s.dwen = 1;
    step(s, 1'b0);
    step(s, 1'b0);
    step(s, 1'b1);
    s.dwen = 0;
    step(s, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      s.ihit    = ($urandom_range(0, 3) != 0);
      s.dren    = ($urandom_range(0, 5) == 0);
      s.dwen    = ($urandom_range(0, 7) == 0);
      s.dhit    = ($urandom_range(0, 2) != 0);
      s.br      = ($urandom_range(0, 9) == 0);
      s.j       = ($urandom_range(0, 19) == 0);
      s.jr      = ($urandom_range(0, 19) == 0);
      s.halt    = ($urandom_range(0, 299) == 0);
      s.ex_load = ($urandom_range(0, 2) == 0);
      s.uses_rt = $urandom_range(0, 1);
      s.ex_rt   = 5'($urandom_range(0, 3));
      s.id_rs   = 5'($urandom_range(0, 3));
      s.id_rt   = 5'($urandom_range(0, 3));
      rst = ($urandom_range(0, 249) == 0) || (m_halted && $urandom_range(0, 19) == 0);
      step(s, rst);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
